vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_plot_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Two-player pixel-plot arbiter in front of a VGA adapter, with an optional full-screen clear sweep.
// Define PLOT_CLEAR_EN to build the CLEAR state, clear_req handling and the power-on clear.
module vga_plot_arbiter #(
   parameter int         WIDTH        = 100,
   parameter int         HEIGHT       = 100,
   parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear_req,
   input  logic       p1_req,
   input  logic [6:0] p1_x,
   input  logic [6:0] p1_y,
   input  logic [2:0] p1_colour,
   output logic       p1_ack,
   input  logic       p2_req,
   input  logic [6:0] p2_x,
   input  logic [6:0] p2_y,
   input  logic [2:0] p2_colour,
   output logic       p2_ack,
   output logic [6:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy
);

`ifdef PLOT_CLEAR_EN
   localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;
   localparam state_t RESET_STATE = CLEAR;
`else
   typedef enum logic {ARB = 1'b0} state_t;
   localparam state_t RESET_STATE = ARB;
`endif

   state_t     state_reg;
   state_t     state_next;

   logic       in_clear;
   logic       clear_go;
   logic [6:0] sweep_x;
   logic [6:0] sweep_y;

   logic       grant1;
   logic       grant2;
   logic       last_p1_reg;

   logic [6:0] x_reg, x_next;
   logic [6:0] y_reg, y_next;
   logic [2:0] colour_reg, colour_next;
   logic       plot_reg, plot_next;
   logic       p1_ack_reg, p1_ack_next;
   logic       p2_ack_reg, p2_ack_next;
   logic       busy_reg, busy_next;

`ifdef PLOT_CLEAR_EN
   logic [COL_W-1:0] col_reg;
   logic [ROW_W-1:0] row_reg;
   logic             sweep_last;

   assign in_clear   = (state_reg == CLEAR);
   assign clear_go   = (state_reg == ARB) && clear_req;
   assign sweep_last = (col_reg == COL_W'(WIDTH - 1)) && (row_reg == ROW_W'(HEIGHT - 1));
   assign sweep_x    = 7'(col_reg);
   assign sweep_y    = 7'(row_reg);

   // Counters idle at zero outside CLEAR, so every sweep starts from (0,0).
   always_ff @(posedge clk) begin
      if (!reset_n || !in_clear) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (col_reg == COL_W'(WIDTH - 1)) begin
         col_reg <= '0;
         row_reg <= row_reg + 1'b1;
      end else begin
         col_reg <= col_reg + 1'b1;
      end
   end
`else
   logic unused_clear;

   assign unused_clear = clear_req;
   assign in_clear     = 1'b0;
   assign clear_go     = 1'b0;
   assign sweep_x      = 7'd0;
   assign sweep_y      = 7'd0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= RESET_STATE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
`ifdef PLOT_CLEAR_EN
      case (state_reg)
         ARB:     if (clear_req) state_next = CLEAR;
         CLEAR:   if (sweep_last) state_next = ARB;
         default: state_next = ARB;
      endcase
`endif
   end

   // A clear request wins over both players in the cycle it is seen.
   always_comb begin
      grant1 = 1'b0;
      grant2 = 1'b0;
      if ((state_reg == ARB) && !clear_go) begin
         if (p1_req && p2_req) begin
            grant1 = !last_p1_reg;
            grant2 = last_p1_reg;
         end else begin
            grant1 = p1_req;
            grant2 = p2_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_p1_reg <= 1'b0;
      end else if (grant1) begin
         last_p1_reg <= 1'b1;
      end else if (grant2) begin
         last_p1_reg <= 1'b0;
      end
   end

   function automatic logic on_screen(input logic [6:0] px, input logic [6:0] py);
      return (int'(px) < WIDTH) && (int'(py) < HEIGHT);
   endfunction

   always_comb begin
      x_next      = x_reg;
      y_next      = y_reg;
      colour_next = colour_reg;
      plot_next   = 1'b0;
      p1_ack_next = 1'b0;
      p2_ack_next = 1'b0;
      busy_next   = 1'b0;
      if (in_clear) begin
         x_next      = sweep_x;
         y_next      = sweep_y;
         colour_next = CLEAR_COLOUR;
         plot_next   = 1'b1;
         busy_next   = 1'b1;
      end else if (grant1) begin
         x_next      = p1_x;
         y_next      = p1_y;
         colour_next = p1_colour;
         plot_next   = on_screen(p1_x, p1_y);
         p1_ack_next = 1'b1;
      end else if (grant2) begin
         x_next      = p2_x;
         y_next      = p2_y;
         colour_next = p2_colour;
         plot_next   = on_screen(p2_x, p2_y);
         p2_ack_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_reg      <= '0;
         y_reg      <= '0;
         colour_reg <= '0;
         plot_reg   <= 1'b0;
         p1_ack_reg <= 1'b0;
         p2_ack_reg <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         x_reg      <= x_next;
         y_reg      <= y_next;
         colour_reg <= colour_next;
         plot_reg   <= plot_next;
         p1_ack_reg <= p1_ack_next;
         p2_ack_reg <= p2_ack_next;
         busy_reg   <= busy_next;
      end
   end

   assign x      = x_reg;
   assign y      = y_reg;
   assign colour = colour_reg;
   assign plot   = plot_reg;
   assign p1_ack = p1_ack_reg;
   assign p2_ack = p2_ack_reg;
   assign busy   = busy_reg;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus random two-player traffic.
// Clear-sweep scenarios are compiled in when PLOT_CLEAR_EN is defined.
module tb_vga_plot_arbiter;
   localparam int W = 100;
   localparam int H = 100;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clear_req = 1'b0;
   logic       p1_req = 1'b0;
   logic [6:0] p1_x = '0;
   logic [6:0] p1_y = '0;
   logic [2:0] p1_colour = '0;
   logic       p1_ack;
   logic       p2_req = 1'b0;
   logic [6:0] p2_x = '0;
   logic [6:0] p2_y = '0;
   logic [2:0] p2_colour = '0;
   logic       p2_ack;
   logic [6:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;

   int total = 0;
   int bad = 0;

   vga_plot_arbiter #(.WIDTH(W), .HEIGHT(H), .CLEAR_COLOUR(3'b000)) dut (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
      .p1_req(p1_req), .p1_x(p1_x), .p1_y(p1_y), .p1_colour(p1_colour), .p1_ack(p1_ack),
      .p2_req(p2_req), .p2_x(p2_x), .p2_y(p2_y), .p2_colour(p2_colour), .p2_ack(p2_ack),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_p1(input int r, input int px, input int py, input int pc);
      p1_req = (r != 0); p1_x = 7'(px); p1_y = 7'(py); p1_colour = 3'(pc);
   endtask

   task automatic set_p2(input int r, input int px, input int py, input int pc);
      p2_req = (r != 0); p2_x = 7'(px); p2_y = 7'(py); p2_colour = 3'(pc);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; clear_req = 1'b0;
      set_p1(0, 0, 0, 0); set_p2(0, 0, 0, 0);
      tick(); tick();
      reset_n = 1'b1;
   endtask

   // Walk one full sweep; optionally re-pulse clear_req part way through.
   task automatic check_sweep(input int poke);
      int errs = 0;
      for (int i = 0; i < W * H; i++) begin
         tick();
         clear_req = (poke != 0) && (i == 500);
         if (i == 0) begin
            chk("sweep_first_x", int'(x), 0);
            chk("sweep_first_y", int'(y), 0);
         end
         if (i == W * H - 1) begin
            chk("sweep_last_x", int'(x), W - 1);
            chk("sweep_last_y", int'(y), H - 1);
         end
         if (int'(x) != i % W || int'(y) != i / W || plot !== 1'b1 || busy !== 1'b1 ||
             colour !== 3'b000 || p1_ack !== 1'b0 || p2_ack !== 1'b0)
            errs++;
      end
      clear_req = 1'b0;
      chk("sweep_pixels", errs, 0);
      $display("sweep: %0d cycles walked, %0d bad pixels", W * H, errs);
   endtask

   task automatic settle_after_reset();
`ifdef PLOT_CLEAR_EN
      check_sweep(0);
`endif
      tick();
      chk("idle_plot", int'(plot), 0);
      chk("idle_busy", int'(busy), 0);
   endtask

   initial begin
      int r1, r2, d1x, d1y, d1c, d2x, d2y, d2c, g, last, exp_plot, found;

      // Reset values
      reset_n = 1'b0;
      tick(); tick(); tick();
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_plot", int'(plot), 0);
      chk("rst_p1_ack", int'(p1_ack), 0);
      chk("rst_p2_ack", int'(p2_ack), 0);
      chk("rst_busy", int'(busy), 0);
      reset_n = 1'b1;
      settle_after_reset();

      // Contention right after reset: p1 first, then alternate
      set_p1(1, 1, 2, 1); set_p2(1, 3, 4, 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("cont_p1_ack", int'(p1_ack), (i % 2 == 0) ? 1 : 0);
         chk("cont_p2_ack", int'(p2_ack), (i % 2 == 0) ? 0 : 1);
         chk("cont_plot", int'(plot), 1);
         chk("cont_x", int'(x), (i % 2 == 0) ? 1 : 3);
         $display("contention cycle %0d: p1_ack=%0d p2_ack=%0d", i, p1_ack, p2_ack);
      end
      set_p1(0, 0, 0, 0); set_p2(0, 0, 0, 0);
      tick();
      chk("cont_drop_plot", int'(plot), 0);
      chk("cont_drop_ack", int'(p1_ack | p2_ack), 0);

      // Single request
      set_p1(1, 10, 20, 4);
      tick();
      set_p1(0, 0, 0, 0);
      chk("single_x", int'(x), 10);
      chk("single_y", int'(y), 20);
      chk("single_colour", int'(colour), 4);
      chk("single_plot", int'(plot), 1);
      chk("single_p1_ack", int'(p1_ack), 1);
      chk("single_p2_ack", int'(p2_ack), 0);
      $display("single: (%0d,%0d) c=%0d plot=%0d", x, y, colour, plot);
      tick();
      chk("pulse_plot", int'(plot), 0);
      chk("pulse_ack", int'(p1_ack), 0);

      // Screen-edge boundaries
      set_p2(1, 100, 5, 7);
      tick(); set_p2(0, 0, 0, 0);
      chk("oor_x_ack", int'(p2_ack), 1);
      chk("oor_x_plot", int'(plot), 0);
      set_p1(1, 5, 100, 2);
      tick(); set_p1(0, 0, 0, 0);
      chk("oor_y_ack", int'(p1_ack), 1);
      chk("oor_y_plot", int'(plot), 0);
      set_p2(1, 99, 99, 5);
      tick(); set_p2(0, 0, 0, 0);
      chk("edge_ack", int'(p2_ack), 1);
      chk("edge_plot", int'(plot), 1);
      chk("edge_x", int'(x), 99);
      $display("boundaries: done");

`ifdef PLOT_CLEAR_EN
      // Clear and request together: clear wins, p1 waits out the sweep
      clear_req = 1'b1; set_p1(1, 12, 34, 6);
      tick();
      clear_req = 1'b0;
      chk("clr_req_ack", int'(p1_ack), 0);
      chk("clr_req_plot", int'(plot), 0);
      check_sweep(1);
      tick();
      set_p1(0, 0, 0, 0);
      chk("clr_after_ack", int'(p1_ack), 1);
      chk("clr_after_busy", int'(busy), 0);
      chk("clr_after_plot", int'(plot), 1);
      chk("clr_after_x", int'(x), 12);

      // Reset in the middle of a sweep
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      found = 0;
      for (int i = 0; i < 2 * W * H && found == 0; i++) begin
         tick();
         if (plot === 1'b1 && int'(x) == 50 && int'(y) == 3) found = 1;
      end
      chk("find_50_3", found, 1);
      reset_n = 1'b0;
      tick();
      chk("midrst_plot", int'(plot), 0);
      chk("midrst_busy", int'(busy), 0);
      reset_n = 1'b1;
      settle_after_reset();
`else
      // clear_req has no effect without the clear feature
      clear_req = 1'b1; set_p1(1, 7, 8, 3);
      tick();
      clear_req = 1'b0; set_p1(0, 0, 0, 0);
      chk("noclr_ack", int'(p1_ack), 1);
      chk("noclr_plot", int'(plot), 1);
      chk("noclr_busy", int'(busy), 0);
`endif

      // Random traffic against the round-robin rules
      do_reset();
      settle_after_reset();
      last = 2;
      r1 = 0; r2 = 0;
      d1x = 0; d1y = 0; d1c = 0; d2x = 0; d2y = 0; d2c = 0;
      for (int n = 0; n < 400; n++) begin
         if (r1 == 0 && $urandom_range(0, 1) == 1) begin
            r1 = 1; d1x = $urandom_range(0, 110); d1y = $urandom_range(0, 110); d1c = $urandom_range(0, 7);
         end
         if (r2 == 0 && $urandom_range(0, 1) == 1) begin
            r2 = 1; d2x = $urandom_range(0, 110); d2y = $urandom_range(0, 110); d2c = $urandom_range(0, 7);
         end
`ifndef PLOT_CLEAR_EN
         clear_req = ($urandom_range(0, 3) == 0);
`endif
         set_p1(r1, d1x, d1y, d1c);
         set_p2(r2, d2x, d2y, d2c);
         if (r1 != 0 && r2 != 0) g = (last == 1) ? 2 : 1;
         else if (r1 != 0) g = 1;
         else if (r2 != 0) g = 2;
         else g = 0;
         tick();
         if (g == 1) exp_plot = (d1x < W && d1y < H) ? 1 : 0;
         else if (g == 2) exp_plot = (d2x < W && d2y < H) ? 1 : 0;
         else exp_plot = 0;
         chk("rnd_p1_ack", int'(p1_ack), (g == 1) ? 1 : 0);
         chk("rnd_p2_ack", int'(p2_ack), (g == 2) ? 1 : 0);
         chk("rnd_plot", int'(plot), exp_plot);
         chk("rnd_busy", int'(busy), 0);
         if (g != 0) begin
            chk("rnd_x", int'(x), (g == 1) ? d1x : d2x);
            chk("rnd_y", int'(y), (g == 1) ? d1y : d2y);
            chk("rnd_colour", int'(colour), (g == 1) ? d1c : d2c);
            $display("txn %0d: p%0d (%0d,%0d) c=%0d plot=%0d", n, g, x, y, colour, plot);
            last = g;
            if (g == 1) r1 = 0; else r2 = 0;
         end
      end
      clear_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
